// File: rtl/mole_pkg.sv
// mole_pkg: shared FSM encoding and default LFSR/board constants for the box picker
package mole_pkg;
    typedef enum logic {ST_IDLE, ST_DRAW} state_t;
    localparam logic [2:0]  TAPS_W3       = 3'b110;
    localparam logic [7:0]  TAPS_W8       = 8'hB8;
    localparam logic [15:0] TAPS_W16      = 16'hB400;
    localparam int          DEF_BOX_W     = 2;
    localparam int          DEF_NUM_BOXES = 4;
endpackage

// File: rtl/lfsr_core.sv
// lfsr_core: Fibonacci LFSR with load port; zero seeds are forced to 1 so it never locks up
module lfsr_core #(
    parameter int               WIDTH = 8,
    parameter logic [WIDTH-1:0] TAPS  = 8'hB8,
    parameter logic [WIDTH-1:0] SEED  = 8'h01
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             i_step,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    output logic [WIDTH-1:0] o_state
);
    localparam logic [WIDTH-1:0] SEED_NZ = (SEED == '0) ? WIDTH'(1) : SEED;
    logic [WIDTH-1:0] r_state;
    assign o_state = r_state;
    // load wins over shift; shift feeds XOR of tapped bits into the LSB
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            r_state <= SEED_NZ;
        else if (i_load)
            r_state <= (i_load_val == '0) ? WIDTH'(1) : i_load_val;
        else if (i_step)
            r_state <= {r_state[WIDTH-2:0], ^(r_state & TAPS)};
    end
endmodule

// File: rtl/lfsr_box_picker.sv
// lfsr_box_picker: draws a uniform box index from an LFSR by rejection sampling with bounded retries
module lfsr_box_picker
    import mole_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] TAPS      = TAPS_W8,
    parameter logic [WIDTH-1:0] SEED      = 8'h01,
    parameter int               NUM_BOXES = DEF_NUM_BOXES,
    parameter int               BOX_W     = DEF_BOX_W,
    parameter bit               NO_REPEAT = 1'b0,
    parameter int               MAX_TRIES = 8
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             en,
    input  logic             seed_load,
    input  logic [WIDTH-1:0] seed_val,
    input  logic             req,
    output logic             busy,
    output logic             valid,
    output logic [BOX_W-1:0] box,
    output logic             fallback,
    output logic [WIDTH-1:0] lfsr_state
);
    localparam int             TW = $clog2(MAX_TRIES + 1);
    localparam logic [BOX_W:0] NB = (BOX_W + 1)'(NUM_BOXES);

    if (NUM_BOXES > (1 << BOX_W)) begin : g_err_nb
        $error("NUM_BOXES exceeds 2**BOX_W");
    end
    if (BOX_W > WIDTH) begin : g_err_bw
        $error("BOX_W exceeds WIDTH");
    end
    if (MAX_TRIES < 1) begin : g_err_mt
        $error("MAX_TRIES must be at least 1");
    end
    if (NO_REPEAT && NUM_BOXES < 2) begin : g_err_nr
        $error("NO_REPEAT needs at least 2 boxes");
    end

    state_t           r_state;
    logic [BOX_W-1:0] r_box;
    logic [BOX_W-1:0] r_last;
    logic             r_valid;
    logic             r_busy;
    logic             r_fallback;
    logic [TW-1:0]    r_tries;
    logic [WIDTH-1:0] w_lfsr;
    logic [BOX_W-1:0] w_cand;
    logic             w_accept;
    logic [TW-1:0]    w_tries_nx;
    logic             w_give_up;
    logic [BOX_W:0]   w_last_inc;
    logic [BOX_W-1:0] w_fb_box;

    lfsr_core #(.WIDTH(WIDTH), .TAPS(TAPS), .SEED(SEED)) u_lfsr (
        .clk        (clk),
        .resetn     (resetn),
        .i_step     (en),
        .i_load     (seed_load && r_state == ST_IDLE),
        .i_load_val (seed_val),
        .o_state    (w_lfsr)
    );

    assign w_cand     = w_lfsr[BOX_W-1:0];
    assign w_accept   = ({1'b0, w_cand} < NB) && (!NO_REPEAT || w_cand != r_last);
    assign w_tries_nx = r_tries + TW'(1);
    assign w_give_up  = w_tries_nx == TW'(MAX_TRIES);
    assign w_last_inc = {1'b0, r_last} + (BOX_W + 1)'(1);
    assign w_fb_box   = (w_last_inc == NB) ? '0 : w_last_inc[BOX_W-1:0];

    assign busy       = r_busy;
    assign valid      = r_valid;
    assign box        = r_box;
    assign fallback   = r_fallback;
    assign lfsr_state = w_lfsr;

    // draw FSM: one candidate per enabled edge, valid/fallback are single-cycle pulses
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state    <= ST_IDLE;
            r_box      <= '0;
            r_last     <= '0;
            r_valid    <= 1'b0;
            r_busy     <= 1'b0;
            r_fallback <= 1'b0;
            r_tries    <= '0;
        end else begin
            r_valid    <= 1'b0;
            r_fallback <= 1'b0;
            if (en && r_state == ST_IDLE && req && !seed_load) begin
                r_state <= ST_DRAW;
                r_busy  <= 1'b1;
                r_tries <= '0;
            end else if (en && r_state == ST_DRAW) begin
                if (w_accept || w_give_up) begin
                    r_box      <= w_accept ? w_cand : w_fb_box;
                    r_last     <= w_accept ? w_cand : w_fb_box;
                    r_valid    <= 1'b1;
                    r_fallback <= !w_accept;
                    r_state    <= ST_IDLE;
                    r_busy     <= 1'b0;
                end else begin
                    r_tries <= w_tries_nx;
                end
            end
        end
    end
endmodule
